// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Fetch-stage controller. Sequences the external PC register, runs the
//   req/ack handshake to instruction memory, presents fetched words to the
//   IF/ID boundary, and applies EX-stage redirects and ID-stage stalls.
//
// Ports
//   CLK            system clock, rising edge
//   RESET          asynchronous active-high reset
//   PC             current PC register value
//   PC_in          next-PC value presented to the PC register
//   PCWrite        PC register write enable, active-low (0 = load PC_in)
//   IMEM_REQ       fetch request (registered)
//   IMEM_ADDR      fetch address (always equals PC)
//   IMEM_ACK       fetch complete, IMEM_RDATA valid this cycle
//   IMEM_RDATA     fetched instruction word
//   STALL          ID not accepting
//   BRANCH_TAKEN   single-cycle redirect strobe from EX
//   BRANCH_TARGET  redirect address, valid with BRANCH_TAKEN
//   INSTR          IF/ID instruction (registered)
//   INSTR_VALID    INSTR holds a valid instruction (registered)
//   FLUSH          kill IF/ID contents, combinational, redirect cycle only
//   FAULT          sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int              size         = 32,
    parameter logic [size-1:0] RESET_VECTOR = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [size-1:0] PC,
    output logic [size-1:0] PC_in,
    output logic            PCWrite,
    output logic            IMEM_REQ,
    output logic [size-1:0] IMEM_ADDR,
    input  logic            IMEM_ACK,
    input  logic [31:0]     IMEM_RDATA,
    input  logic            STALL,
    input  logic            BRANCH_TAKEN,
    input  logic [size-1:0] BRANCH_TARGET,
    output logic [31:0]     INSTR,
    output logic            INSTR_VALID,
    output logic            FLUSH,
    output logic            FAULT
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_BUFFERED,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t          r_state;
    logic            r_req;
    logic [31:0]     r_instr;
    logic            r_instr_valid;
    logic [31:0]     r_buf;
    logic            r_fault;
    logic            r_halt_pending;   // DRAIN must end in HALT, not FETCH
    logic [size-1:0] r_target;

    logic            w_redirect;
    logic            w_misaligned;
    logic            w_branch_ok;
    logic            w_pc_load;
    logic [size-1:0] w_pc_next;
    logic [size-1:0] w_pc_plus4;

    // Modulo 2^size: the top word wraps to address zero.
    assign w_pc_plus4 = PC + size'(4);

    // Redirects only mean something once fetching has started and before HALT.
    assign w_redirect   = BRANCH_TAKEN &&
                          ((r_state == S_FETCH) || (r_state == S_BUFFERED) ||
                           (r_state == S_DRAIN));
    assign w_misaligned = w_redirect && (BRANCH_TARGET[1:0] != 2'b00);
    assign w_branch_ok  = w_redirect && !w_misaligned;

    // PC load decision is combinational because it depends on same-cycle
    // ACK, STALL and BRANCH_TAKEN.
    always_comb begin
        w_pc_load = 1'b0;
        w_pc_next = w_pc_plus4;
        case (r_state)
            S_BOOT: begin
                w_pc_load = 1'b1;
                w_pc_next = RESET_VECTOR;
            end
            S_FETCH: begin
                if (w_branch_ok) begin
                    // Without ACK the old request is still in flight; the
                    // target waits in DRAIN instead.
                    if (IMEM_ACK) begin
                        w_pc_load = 1'b1;
                        w_pc_next = BRANCH_TARGET;
                    end
                end else if (!w_misaligned && IMEM_ACK && !STALL) begin
                    w_pc_load = 1'b1;
                end
            end
            S_BUFFERED: begin
                if (w_branch_ok) begin
                    w_pc_load = 1'b1;
                    w_pc_next = BRANCH_TARGET;
                end else if (!w_misaligned && !STALL) begin
                    w_pc_load = 1'b1;
                end
            end
            S_DRAIN: begin
                // A redirect arriving together with the ACK replaces the
                // latched target.
                if (IMEM_ACK && !w_misaligned && !r_halt_pending) begin
                    w_pc_load = 1'b1;
                    w_pc_next = w_branch_ok ? BRANCH_TARGET : r_target;
                end
            end
            default: begin
                w_pc_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= S_BOOT;
            r_req          <= 1'b0;
            r_instr        <= '0;
            r_instr_valid  <= 1'b0;
            r_buf          <= '0;
            r_fault        <= 1'b0;
            r_halt_pending <= 1'b0;
            r_target       <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (w_redirect) begin
                        r_instr_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                        end
                        if (IMEM_ACK) begin
                            r_state <= w_misaligned ? S_HALT : S_FETCH;
                            r_req   <= !w_misaligned;
                        end else begin
                            // Keep the request up with the old address until
                            // memory answers.
                            r_state        <= S_DRAIN;
                            r_target       <= BRANCH_TARGET;
                            r_halt_pending <= w_misaligned;
                        end
                    end else if (IMEM_ACK) begin
                        if (!STALL) begin
                            r_instr       <= IMEM_RDATA;
                            r_instr_valid <= 1'b1;
                        end else begin
                            r_buf   <= IMEM_RDATA;
                            r_state <= S_BUFFERED;
                            r_req   <= 1'b0;
                        end
                    end else if (!STALL) begin
                        r_instr_valid <= 1'b0;
                    end
                end
                S_BUFFERED: begin
                    if (w_redirect) begin
                        r_instr_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_FETCH;
                            r_req   <= 1'b1;
                        end
                    end else if (!STALL) begin
                        r_instr       <= r_buf;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_FETCH;
                        r_req         <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_redirect) begin
                        if (w_misaligned) begin
                            r_fault        <= 1'b1;
                            r_halt_pending <= 1'b1;
                        end else begin
                            r_target <= BRANCH_TARGET;
                        end
                    end
                    if (IMEM_ACK) begin
                        r_halt_pending <= 1'b0;
                        if (r_halt_pending || w_misaligned) begin
                            r_state <= S_HALT;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= S_FETCH;
                            r_req   <= 1'b1;
                        end
                    end
                end
                default: begin
                    // HALT: only RESET leaves this state.
                    r_req         <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_ADDR   = PC;
    assign IMEM_REQ    = r_req;
    assign PC_in       = w_pc_next;
    assign PCWrite     = RESET | !w_pc_load;
    assign FLUSH       = w_redirect;
    assign INSTR       = r_instr;
    assign INSTR_VALID = r_instr_valid;
    assign FAULT       = r_fault;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Bench for pc_fetch_ctrl. Provides a PC register, a variable-latency
//   instruction memory, directed scenarios and a randomized phase. The
//   reference model is program-order: every instruction ID accepts must be
//   the memory word at the next expected address, which restarts at each
//   taken branch target.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic [31:0] PC_in;
    logic        PCWrite;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        FLUSH;
    logic        FAULT;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [31:0] pc_reg;
    int          mem_wait;
    int          mem_lat;

    logic [31:0] exp_addr;
    logic        model_fault;
    logic        prev_pending;
    logic [31:0] prev_addr;
    int          n_consumed;
    logic [31:0] pc_hold;
    int          base_consumed;

    pc_fetch_ctrl #(.size(32), .RESET_VECTOR(RV)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .PC_in(PC_in), .PCWrite(PCWrite),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
        .IMEM_RDATA(IMEM_RDATA), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .FLUSH(FLUSH), .FAULT(FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents: unique word per address, one fixed word at 0x20.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h0000_0020) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // PC register: loads on active-low write enable. Reset value differs
    // from the reset vector so the BOOT load is visible.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) pc_reg <= 32'h0000_0F00;
        else if (!PCWrite) pc_reg <= PC_in;
    end
    assign PC = pc_reg;

    // Instruction memory: ACK after mem_lat waiting cycles (0 = same cycle).
    always @(posedge CLK or posedge RESET) begin
        if (RESET) mem_wait <= 0;
        else if (IMEM_REQ && !IMEM_ACK) mem_wait <= mem_wait + 1;
        else mem_wait <= 0;
    end
    assign IMEM_ACK   = IMEM_REQ && (mem_wait >= mem_lat);
    assign IMEM_RDATA = IMEM_ACK ? word_of(IMEM_ADDR) : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle reference checks, evaluated mid-cycle.
    task automatic model_step();
        check("imem_addr_is_pc", IMEM_ADDR, PC);
        if (prev_pending) begin
            check("req_held", {31'd0, IMEM_REQ}, 32'd1);
            check("addr_held", IMEM_ADDR, prev_addr);
        end
        check("fault_flag", {31'd0, FAULT}, {31'd0, model_fault});
        if (model_fault) begin
            check("halt_pcwrite", {31'd0, PCWrite}, 32'd1);
            check("halt_valid", {31'd0, INSTR_VALID}, 32'd0);
        end else begin
            check("flush", {31'd0, FLUSH}, {31'd0, BRANCH_TAKEN});
        end
        if (INSTR_VALID && !STALL && !BRANCH_TAKEN) begin
            $display("txn accept addr=%h instr=%h", exp_addr, INSTR);
            check("instr_stream", INSTR, word_of(exp_addr));
            exp_addr   = exp_addr + 32'd4;
            n_consumed++;
        end
        if (BRANCH_TAKEN && !model_fault) begin
            $display("txn branch target=%h", BRANCH_TARGET);
            if (BRANCH_TARGET[1:0] == 2'b00) exp_addr = BRANCH_TARGET;
            else model_fault = 1'b1;
        end
        prev_pending = IMEM_REQ && !IMEM_ACK;
        prev_addr    = IMEM_ADDR;
    endtask

    task automatic cyc(input logic st, input logic br, input logic [31:0] tgt, input int lat);
        @(posedge CLK);
        #1;
        STALL         = st;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        mem_lat       = lat;
        @(negedge CLK);
        model_step();
    endtask

    // Asserts RESET for a couple of cycles, checks reset values, releases it
    // and checks the single BOOT cycle.
    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0; mem_lat = 0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_pcwrite", {31'd0, PCWrite}, 32'd1);
        check("rst_pc_in", PC_in, RV);
        check("rst_req", {31'd0, IMEM_REQ}, 32'd0);
        check("rst_instr", INSTR, 32'd0);
        check("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
        check("rst_flush", {31'd0, FLUSH}, 32'd0);
        check("rst_fault", {31'd0, FAULT}, 32'd0);
        exp_addr = RV; model_fault = 1'b0; prev_pending = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        $display("txn reset released");
        check("boot_pcwrite", {31'd0, PCWrite}, 32'd0);
        check("boot_pc_in", PC_in, RV);
        check("boot_req", {31'd0, IMEM_REQ}, 32'd0);
    endtask

    initial begin
        RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
        mem_lat = 0; exp_addr = RV; model_fault = 1'b0; prev_pending = 1'b0;
        prev_addr = '0; n_consumed = 0;

        // Zero-wait memory after reset: one instruction per cycle.
        do_reset();
        cyc(0, 0, 0, 0);
        check("first_req", {31'd0, IMEM_REQ}, 32'd1);
        check("addr_0", IMEM_ADDR, 32'h0);
        check("ack0_pcwrite", {31'd0, PCWrite}, 32'd0);
        check("ack0_pc_in", PC_in, 32'h4);
        check("valid_before", {31'd0, INSTR_VALID}, 32'd0);
        cyc(0, 0, 0, 0);
        check("addr_4", IMEM_ADDR, 32'h4);
        check("valid_rise", {31'd0, INSTR_VALID}, 32'd1);
        check("instr_0", INSTR, word_of(32'h0));
        cyc(0, 0, 0, 0);
        check("addr_8", IMEM_ADDR, 32'h8);
        cyc(0, 0, 0, 0);
        check("addr_c", IMEM_ADDR, 32'hC);

        // Three-cycle memory at 0x10.
        cyc(0, 0, 0, 2);
        check("lat_addr_a", IMEM_ADDR, 32'h10);
        check("lat_pcw_a", {31'd0, PCWrite}, 32'd1);
        cyc(0, 0, 0, 2);
        check("lat_pcw_b", {31'd0, PCWrite}, 32'd1);
        cyc(0, 0, 0, 2);
        check("lat_ack", {31'd0, IMEM_ACK}, 32'd1);
        check("lat_pcw_c", {31'd0, PCWrite}, 32'd0);
        check("lat_pc_in", PC_in, 32'h14);
        cyc(0, 0, 0, 0);
        check("addr_14", IMEM_ADDR, 32'h14);

        // Stall covering the ACK of 0xDEADBEEF at 0x20.
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("stall_addr", IMEM_ADDR, 32'h20);
        check("stall_pcw_a", {31'd0, PCWrite}, 32'd1);
        check("stall_instr_a", INSTR, word_of(32'h1C));
        cyc(1, 0, 0, 0);
        check("stall_req_b", {31'd0, IMEM_REQ}, 32'd0);
        check("stall_pcw_b", {31'd0, PCWrite}, 32'd1);
        check("stall_instr_b", INSTR, word_of(32'h1C));
        cyc(0, 0, 0, 0);
        check("unstall_pcw", {31'd0, PCWrite}, 32'd0);
        check("unstall_pc_in", PC_in, 32'h24);
        cyc(0, 0, 0, 0);
        check("buf_instr", INSTR, 32'hDEAD_BEEF);
        check("buf_valid", {31'd0, INSTR_VALID}, 32'd1);
        check("addr_24", IMEM_ADDR, 32'h24);

        // Redirect to 0x100 while the 0x40 request is outstanding.
        for (int i = 0; i < 20 && IMEM_ADDR != 32'h3C; i++) cyc(0, 0, 0, 0);
        check("reach_3c", IMEM_ADDR, 32'h3C);
        cyc(0, 1, 32'h100, 2);
        check("br_addr", IMEM_ADDR, 32'h40);
        check("br_flush", {31'd0, FLUSH}, 32'd1);
        check("br_pcw", {31'd0, PCWrite}, 32'd1);
        cyc(0, 0, 0, 2);
        check("drain_flush", {31'd0, FLUSH}, 32'd0);
        check("drain_valid", {31'd0, INSTR_VALID}, 32'd0);
        cyc(0, 0, 0, 2);
        check("drain_pcw", {31'd0, PCWrite}, 32'd0);
        check("drain_pc_in", PC_in, 32'h100);
        cyc(0, 0, 0, 0);
        check("tgt_addr", IMEM_ADDR, 32'h100);
        check("tgt_valid", {31'd0, INSTR_VALID}, 32'd0);
        cyc(0, 0, 0, 0);
        check("tgt_instr", INSTR, word_of(32'h100));

        // Redirect and stall together.
        cyc(1, 1, 32'h200, 0);
        check("bs_pcw", {31'd0, PCWrite}, 32'd0);
        check("bs_pc_in", PC_in, 32'h200);
        check("bs_flush", {31'd0, FLUSH}, 32'd1);
        cyc(0, 0, 0, 0);
        check("bs_addr", IMEM_ADDR, 32'h200);
        check("bs_valid", {31'd0, INSTR_VALID}, 32'd0);

        // PC wrap at the top of the address space.
        cyc(0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 0, 0, 0);
        check("wrap_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        check("wrap_pc_in", PC_in, 32'h0);
        cyc(0, 0, 0, 0);
        check("wrap_zero", IMEM_ADDR, 32'h0);

        // Randomized traffic, checked by the program-order model.
        base_consumed = n_consumed;
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 6),
                $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3));
        end
        check("progress", {31'd0, ((n_consumed - base_consumed) > 200)}, 32'd1);

        // Misaligned redirect with zero-wait memory, then HALT.
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h102, 0);
        check("mis_flush", {31'd0, FLUSH}, 32'd1);
        check("mis_pcw", {31'd0, PCWrite}, 32'd1);
        pc_hold = PC;
        repeat (4) begin
            cyc(0, 0, 0, 0);
            check("halt_req", {31'd0, IMEM_REQ}, 32'd0);
            check("halt_pc", PC, pc_hold);
        end

        // Reset out of HALT restarts at the reset vector.
        do_reset();
        cyc(0, 0, 0, 3);
        check("restart_addr", IMEM_ADDR, RV);
        check("restart_req", {31'd0, IMEM_REQ}, 32'd1);

        // Misaligned redirect with a request outstanding: drain, then HALT.
        cyc(0, 1, 32'h46, 3);
        check("mis2_flush", {31'd0, FLUSH}, 32'd1);
        check("mis2_req", {31'd0, IMEM_REQ}, 32'd1);
        for (int i = 0; i < 8 && IMEM_REQ; i++) cyc(0, 0, 0, 3);
        check("mis2_drained", {31'd0, IMEM_REQ}, 32'd0);
        cyc(0, 0, 0, 3);
        check("mis2_pc", PC, RV);
        check("mis2_fault", {31'd0, FAULT}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
